// File: rtl/seq_multiplier_pkg.sv
// Shared ALU definitions: multiplier FSM states, default operand width and
// a counter-width helper.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } mul_state_t;

  localparam int unsigned ALU_W = 8;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_multiplier_negate.sv
// Parametric two's-complement negation, used for operand magnitudes and the
// final sign fix of the product.
module negate_w #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = ~x + W'(1);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed shift-and-add multiplier: multiplies operand magnitudes
// over WIDTH cycles, then applies the sign in a final step.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               neg,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = clog2(WIDTH);

  mul_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mq;
  logic [WIDTH:0]   acc_hi;
  logic             sgn;

  logic [WIDTH-1:0] neg_a;
  logic [WIDTH-1:0] neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    u;
  logic [PW-1:0]    neg_u;

  negate_w #(.W(WIDTH)) u_neg_a (.x(A), .y(neg_a));
  negate_w #(.W(WIDTH)) u_neg_b (.x(B), .y(neg_b));
  negate_w #(.W(PW))    u_neg_p (.x(u), .y(neg_u));

  // The most negative operand negates to itself, which read unsigned is its magnitude.
  assign abs_a  = A[WIDTH-1] ? neg_a : A;
  assign abs_b  = B[WIDTH-1] ? neg_b : B;
  assign addend = mq[0] ? {1'b0, mag_a} : '0;
  assign sum    = acc_hi + addend;
  assign u      = {acc_hi[WIDTH-1:0], mq};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mag_a  <= '0;
      mq     <= '0;
      acc_hi <= '0;
      sgn    <= 1'b0;
      P      <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a  <= abs_a;
            mq     <= abs_b;
            sgn    <= A[WIDTH-1] ^ B[WIDTH-1];
            acc_hi <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // Conditional add, then shift {carry, acc_hi, mq} right by one.
          acc_hi <= {1'b0, sum[WIDTH:1]};
          mq     <= {sum[0], mq[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          P     <= sgn ? neg_u : u;
          neg   <= sgn && (u != '0);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expected products are queued at issue
// and compared whenever done pulses.
module tb_seq_multiplier;

  localparam int unsigned W   = 8;
  localparam int unsigned LAT = W + 1;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic           neg;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] p;
  logic           neg;
  logic           busy;
  logic           done;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (a),
    .B    (b),
    .P    (p),
    .neg  (neg),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    int   xi;
    int   yi;
    int   prod;
    exp_t e;
    xi    = int'($signed(x));
    yi    = int'($signed(y));
    prod  = xi * yi;
    e.p   = (2*W)'(prod);
    e.neg = (prod < 0);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest queued result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_with_done busy=%b required=0", busy);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done P=%h neg=%b", p, neg);
      end else begin
        e = sb.pop_front();
        if (p !== e.p || neg !== e.neg) begin
          errors++;
          $display("FAIL result P=%h neg=%b required P=%h neg=%b", p, neg, e.p, e.neg);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(model(x, y));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout waited=%0d cycles", lat);
    end
  endtask

  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    issue(x, y);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== int'(LAT)) begin
      errors++;
      $display("FAIL latency %0d*%0d got=%0d required=%0d", $signed(x), $signed(y), lat, LAT);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (p !== '0)     begin errors++; $display("FAIL reset_p got=%h required=0", p); end
    checks++;
    if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg got=%b required=0", neg); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int busy_cnt;
    issue(8'd7, 8'd3);
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== int'(LAT)) begin errors++; $display("FAIL basic_latency got=%0d required=%0d", lat, LAT); end
    checks++;
    if (busy_cnt !== int'(LAT)) begin errors++; $display("FAIL basic_busy_cycles got=%0d required=%0d", busy_cnt, LAT); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width done=%b required=0", done); end
    checks++;
    if (p !== 16'h0015) begin errors++; $display("FAIL p_hold got=%h required=0015", p); end
  endtask

  task automatic test_signed();
    logic [W-1:0] ta[8];
    logic [W-1:0] tb[8];
    ta = '{8'hFB, 8'hFA, 8'h80, 8'h80, 8'h00, 8'h7F, 8'h01, 8'hFF};
    tb = '{8'h03, 8'hF9, 8'h80, 8'h7F, 8'hF9, 8'h7F, 8'h80, 8'hFF};
    for (int i = 0; i < 8; i++) do_mul(ta[i], tb[i]);
    for (int i = 0; i < 6; i++) do_mul(W'($urandom), W'($urandom));
  endtask

  task automatic test_busy_ignore();
    int lat;
    issue(8'd5, 8'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a     = 8'd9;
    b     = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    issue(8'd9, 8'd9);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== int'(LAT)) begin errors++; $display("FAIL done_cycle_accept_latency got=%0d required=%0d", lat, LAT); end
  endtask

  task automatic test_reset_mid();
    int seen;
    a     = 8'd7;
    b     = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (p !== '0)      begin errors++; $display("FAIL abort_p got=%h required=0", p); end
    checks++;
    if (neg !== 1'b0)  begin errors++; $display("FAIL abort_neg got=%b required=0", neg); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b required=0", busy); end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done pulses=%0d required=0", seen); end
    a     = 8'd3;
    b     = 8'd3;
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_beats_start busy=%b required=0", busy); end
    do_mul(8'd2, 8'd3);
  endtask

  task automatic test_operand_change();
    int lat;
    issue(8'd12, 8'hFC);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL operand_change_timeout waited=%0d", lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(8'd3, 8'd4);
    for (int i = 0; i < 3; i++) begin
      wait_done(lat);
      issue(W'($urandom), W'($urandom));
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_basic();
    test_signed();
    test_busy_ignore();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL results_outstanding got=%0d required=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
